ysyx_25020037_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_25020037_mem_arbiter
// PURPOSE
//   Shares one AXI4-Lite slave port (unified SRAM/bus) between two masters: the IFU
//   (read-only) and the LSU (read + write). One transaction in flight at a time, fair
//   round-robin between masters, and a grant is held until its response handshake.
//   Sits between the IFU/LSU and the memory or crossbar.
// PARAMETERS
//   ADDR_W    32  address width, all AR/AW channels
//   DATA_W    32  data width, R/W channels; wstrb width is DATA_W/8
// PORTS
//   clk                                 in   1        clock, rising edge
//   rst                                 in   1        asynchronous reset, active-high
//   ifu_ar{addr,valid} / ifu_arready    in/out        ADDR_W,1 / 1      IFU read address
//   ifu_r{data,resp,valid} / ifu_rready out/in        DATA_W,2,1 / 1    IFU read data
//   lsu_ar{addr,valid} / lsu_arready    in/out        ADDR_W,1 / 1      LSU read address
//   lsu_r{data,resp,valid} / lsu_rready out/in        DATA_W,2,1 / 1    LSU read data
//   lsu_aw{addr,valid} / lsu_awready    in/out        ADDR_W,1 / 1      LSU write address
//   lsu_w{data,strb,valid} / lsu_wready in/out        DATA_W,DATA_W/8,1 / 1  LSU write data
//   lsu_b{resp,valid} / lsu_bready      out/in        2,1 / 1           LSU write response
//   mem_ar*, mem_r*, mem_aw*, mem_w*, mem_b*          mirror of the master channels, slave side
//   grant                               out  2        0=IDLE 1=IFU_RD 2=LSU_RD 3=LSU_WR (state)
// BEHAVIOUR
//   - FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR; grant = state encoding.
//   - Reset: state=IDLE, last_master=LSU (IFU wins the first tie). All outputs are 0 while
//     in reset and whenever they are not routed.
//   - IDLE: requests are ifu_arvalid, lsu_arvalid and lsu_awvalid (lsu_wvalid alone is not a
//     request). LSU request = lsu_awvalid | lsu_arvalid; within the LSU, write wins over read.
//     IFU vs LSU: if both request, grant the master that is not last_master; if only one
//     requests, grant it. The grant is registered: a request at cycle N gives the grant state
//     at N+1. No mem_* valid is asserted in IDLE.
//   - Grant states route the granted master's channels combinationally to mem_* and back,
//     with no added latency. Every other master's ready and valid outputs are held at 0.
//     IFU_RD and LSU_RD route AR and R. LSU_WR routes AW, W and B; AW and W handshake
//     independently in either order or in the same cycle.
//   - Completion: IFU_RD/LSU_RD -> IDLE on mem_rvalid & mem_rready; LSU_WR -> IDLE on
//     mem_bvalid & mem_bready. On completion, last_master := the completing master. The
//     next grant decision is made in IDLE, so there is 1 idle cycle between transactions.
//   - Response codes (rresp/bresp) pass through unmodified, including SLVERR/DECERR; error
//     handling belongs to the master.
//   - Masters must hold valid/addr stable until their handshake (AXI rule). A master's valid
//     raised mid-grant for the other master waits; no request is dropped.
//   - A second AR from the granted master after its AR handshake is not forwarded
//     (mem_arvalid is masked once the AR handshake completes, until return to IDLE).
//   - Async reset mid-transaction returns to IDLE immediately. The in-flight response is
//     discarded; the slave is reset by the same rst.
// TESTING
//   1 IFU only: araddr=0x8000_0000, mem returns rdata=0x0000_0413 after 3 cyc ->
//     ifu_rdata=0x413, grant seq 0,1,...,0; lsu_*ready stays 0.
//   2 IFU and LSU read asserted together, right after reset -> IFU served first, then LSU;
//     the next simultaneous tie is won by the master not served last (alternation over 4 rounds).
//   3 LSU write: awaddr=0x8000_0100, wdata=0xDEAD_BEEF, wstrb=4'hF, with W a cycle before
//     AW -> exactly one mem AW and one W handshake, lsu_bvalid echoed, grant=3 until B done.
//   4 LSU asserts awvalid and arvalid together -> LSU_WR granted first, LSU_RD after IDLE.
//   5 mem_rresp=2'b10 on an IFU read -> ifu_rresp=2'b10 and the FSM still returns to IDLE.
//   6 rst pulsed while in LSU_RD waiting on R -> grant=0 same cycle, all mem valids 0,
//     next tie goes to IFU.

Source files
------------

// File: rtl/ysyx_25020037_mem_arbiter.sv
// Two-master AXI4-Lite arbiter: IFU (read) and LSU (read/write) share one slave port.
// One transaction in flight; round-robin on ties; grant held until the response handshake.
module ysyx_25020037_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   // IFU read
   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic [1:0]          ifu_rresp,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,
   // LSU read
   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic [1:0]          lsu_rresp,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,
   // LSU write
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   input  logic                lsu_awvalid,
   output logic                lsu_awready,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   input  logic                lsu_wvalid,
   output logic                lsu_wready,
   output logic [1:0]          lsu_bresp,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,
   // slave side
   output logic [ADDR_W-1:0]   mem_araddr,
   output logic                mem_arvalid,
   input  logic                mem_arready,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic [1:0]          mem_rresp,
   input  logic                mem_rvalid,
   output logic                mem_rready,
   output logic [ADDR_W-1:0]   mem_awaddr,
   output logic                mem_awvalid,
   input  logic                mem_awready,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic                mem_wvalid,
   input  logic                mem_wready,
   input  logic [1:0]          mem_bresp,
   input  logic                mem_bvalid,
   output logic                mem_bready,
   output logic [1:0]          grant
);

   typedef enum logic [1:0] {IDLE = 2'd0, IFU_RD = 2'd1, LSU_RD = 2'd2, LSU_WR = 2'd3} state_t;

   state_t state;
   logic   last_lsu;
   logic   ar_done, aw_done, w_done;

   logic ifu_req, lsu_req;
   assign ifu_req = ifu_arvalid;
   assign lsu_req = lsu_awvalid | lsu_arvalid;
   assign grant   = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         last_lsu <= 1'b1;
         ar_done  <= 1'b0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ar_done <= 1'b0;
               aw_done <= 1'b0;
               w_done  <= 1'b0;
               // IFU takes a tie only when the LSU was served last
               if (ifu_req && (!lsu_req || last_lsu)) state <= IFU_RD;
               else if (lsu_req)                       state <= lsu_awvalid ? LSU_WR : LSU_RD;
            end
            IFU_RD, LSU_RD: begin
               if (mem_arvalid && mem_arready) ar_done <= 1'b1;
               if (mem_rvalid && mem_rready) begin
                  state    <= IDLE;
                  last_lsu <= (state == LSU_RD);
               end
            end
            LSU_WR: begin
               if (mem_awvalid && mem_awready) aw_done <= 1'b1;
               if (mem_wvalid && mem_wready)   w_done  <= 1'b1;
               if (mem_bvalid && mem_bready) begin
                  state    <= IDLE;
                  last_lsu <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Pure routing: everything not owned by the current grant is driven to zero.
   always_comb begin
      ifu_arready = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = 2'b00;
      ifu_rvalid  = 1'b0;
      lsu_arready = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = 2'b00;
      lsu_rvalid  = 1'b0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bresp   = 2'b00;
      lsu_bvalid  = 1'b0;
      mem_araddr  = '0;
      mem_arvalid = 1'b0;
      mem_rready  = 1'b0;
      mem_awaddr  = '0;
      mem_awvalid = 1'b0;
      mem_wdata   = '0;
      mem_wstrb   = '0;
      mem_wvalid  = 1'b0;
      mem_bready  = 1'b0;
      case (state)
         IFU_RD: begin
            mem_araddr  = ifu_araddr;
            mem_arvalid = ifu_arvalid & ~ar_done;
            ifu_arready = mem_arready & ~ar_done;
            ifu_rdata   = mem_rdata;
            ifu_rresp   = mem_rresp;
            ifu_rvalid  = mem_rvalid;
            mem_rready  = ifu_rready;
         end
         LSU_RD: begin
            mem_araddr  = lsu_araddr;
            mem_arvalid = lsu_arvalid & ~ar_done;
            lsu_arready = mem_arready & ~ar_done;
            lsu_rdata   = mem_rdata;
            lsu_rresp   = mem_rresp;
            lsu_rvalid  = mem_rvalid;
            mem_rready  = lsu_rready;
         end
         LSU_WR: begin
            mem_awaddr  = lsu_awaddr;
            mem_awvalid = lsu_awvalid & ~aw_done;
            lsu_awready = mem_awready & ~aw_done;
            mem_wdata   = lsu_wdata;
            mem_wstrb   = lsu_wstrb;
            mem_wvalid  = lsu_wvalid & ~w_done;
            lsu_wready  = mem_wready & ~w_done;
            lsu_bresp   = mem_bresp;
            lsu_bvalid  = mem_bvalid;
            mem_bready  = lsu_bready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25020037_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: slave model, response and grant scoreboards.
module tb_ysyx_25020037_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [AW-1:0] ifu_araddr, lsu_araddr, lsu_awaddr, mem_araddr, mem_awaddr;
   logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
   logic [DW-1:0] ifu_rdata, lsu_rdata, lsu_wdata, mem_rdata, mem_wdata;
   logic [1:0]    ifu_rresp, lsu_rresp, lsu_bresp, mem_rresp, mem_bresp, grant;
   logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
   logic          lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
   logic [3:0]    lsu_wstrb, mem_wstrb;
   logic          mem_arvalid, mem_arready, mem_rvalid, mem_rready;
   logic          mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;

   ysyx_25020037_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
      .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
      .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
      .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
      .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
      .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
      .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
      .grant(grant)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1234_5678);
   endfunction

   // slave model: 3-cycle read latency, B one cycle after both AW and W
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] wr_data;
   logic [3:0]    wr_strb;
   logic [1:0]    err_resp;
   logic          aw_got, w_got;
   int            rd_cnt;
   int            ar_hs = 0;
   int            aw_hs = 0;
   int            w_hs  = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_rvalid <= 1'b0; mem_rdata <= '0; mem_rresp <= 2'b00; rd_cnt <= 0;
         mem_bvalid <= 1'b0; mem_bresp <= 2'b00; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
         if (mem_rvalid && mem_rready) mem_rvalid <= 1'b0;
         if (mem_arvalid && mem_arready) begin
            rd_addr <= mem_araddr; rd_cnt <= 3; ar_hs <= ar_hs + 1;
         end else if (rd_cnt == 1) begin
            mem_rvalid <= 1'b1; mem_rdata <= mem_fn(rd_addr); mem_rresp <= err_resp; rd_cnt <= 0;
         end else if (rd_cnt > 1) rd_cnt <= rd_cnt - 1;
         if (mem_bvalid && mem_bready) mem_bvalid <= 1'b0;
         if (aw_got && w_got) begin mem_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0; end
         if (mem_awvalid && mem_awready) begin aw_got <= 1'b1; aw_hs <= aw_hs + 1; wr_addr <= mem_awaddr; end
         if (mem_wvalid && mem_wready) begin
            w_got <= 1'b1; w_hs <= w_hs + 1; wr_data <= mem_wdata; wr_strb <= mem_wstrb;
         end
      end
   end

   typedef struct packed {logic [31:0] d; logic [1:0] r;} rexp_t;
   rexp_t      ifu_q[$];
   rexp_t      lsu_q[$];
   logic [1:0] b_q[$];
   logic [1:0] gq[$];
   logic [1:0] prev_g;
   rexp_t      e;

   // response/grant scoreboard and routing-isolation monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_g == 2'd0 && grant != 2'd0) begin
            if (gq.size() == 0) check("grant_unexpected", grant, 0);
            else check("grant_order", grant, gq.pop_front());
         end
         if (ifu_rvalid && ifu_rready) begin
            if (ifu_q.size() == 0) check("ifu_r_unexpected", 1, 0);
            else begin
               e = ifu_q.pop_front();
               check("ifu_rdata", ifu_rdata, e.d);
               check("ifu_rresp", ifu_rresp, e.r);
            end
         end
         if (lsu_rvalid && lsu_rready) begin
            if (lsu_q.size() == 0) check("lsu_r_unexpected", 1, 0);
            else begin
               e = lsu_q.pop_front();
               check("lsu_rdata", lsu_rdata, e.d);
               check("lsu_rresp", lsu_rresp, e.r);
            end
         end
         if (lsu_bvalid && lsu_bready) begin
            if (b_q.size() == 0) check("lsu_b_unexpected", 1, 0);
            else begin
               check("lsu_bresp", lsu_bresp, b_q.pop_front());
               check("grant_during_b", grant, 3);
            end
         end
         case (grant)
            2'd0: check("idle_mem_quiet", {mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready}, 0);
            2'd1: check("ifu_rd_lsu_quiet", {lsu_arready, lsu_awready, lsu_wready, lsu_rvalid, lsu_bvalid}, 0);
            2'd2: check("lsu_rd_others_quiet", {ifu_arready, ifu_rvalid, lsu_awready, lsu_wready, lsu_bvalid}, 0);
            default: check("lsu_wr_others_quiet", {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid}, 0);
         endcase
      end
      prev_g <= grant;
   end

   task automatic ifu_read(input logic [31:0] a);
      bit go = 0, done = 0;
      ifu_araddr = a; ifu_arvalid = 1'b1;
      ifu_q.push_back('{d: mem_fn(a), r: err_resp});
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (go) begin ifu_arvalid = 1'b0; done = 1; break; end
         go = ifu_arready;
      end
      check("ifu_ar_handshake", done, 1);
   endtask

   task automatic lsu_read(input logic [31:0] a);
      bit go = 0, done = 0;
      lsu_araddr = a; lsu_arvalid = 1'b1;
      lsu_q.push_back('{d: mem_fn(a), r: err_resp});
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (go) begin lsu_arvalid = 1'b0; done = 1; break; end
         go = lsu_arready;
      end
      check("lsu_ar_handshake", done, 1);
   endtask

   task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit w_first);
      bit aw_go = 0, w_go = 0, done = 0;
      lsu_wdata = d; lsu_wstrb = s; lsu_wvalid = 1'b1;
      b_q.push_back(2'b00);
      if (w_first) begin
         @(negedge clk);
         check("w_alone_no_grant", {grant, lsu_wready}, 0);
      end
      lsu_awaddr = a; lsu_awvalid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (aw_go) lsu_awvalid = 1'b0;
         if (w_go)  lsu_wvalid  = 1'b0;
         if (!lsu_awvalid && !lsu_wvalid) begin done = 1; break; end
         aw_go = lsu_awvalid && lsu_awready;
         w_go  = lsu_wvalid && lsu_wready;
      end
      check("lsu_aw_w_handshake", done, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         if (ifu_q.size() == 0 && lsu_q.size() == 0 && b_q.size() == 0 && gq.size() == 0 && grant == 2'd0) break;
         @(negedge clk);
      end
      check("drain_all_done", ifu_q.size() + lsu_q.size() + b_q.size() + gq.size(), 0);
   endtask

   int aw0, w0;

   initial begin
      rst = 1'b1;
      ifu_araddr = '0; lsu_araddr = '0; lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0;
      ifu_arvalid = 1'b1; lsu_arvalid = 1'b0; lsu_awvalid = 1'b1; lsu_wvalid = 1'b0;
      ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
      mem_arready = 1'b1; mem_awready = 1'b1; mem_wready = 1'b1; err_resp = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_mem_valids", {mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready}, 0);
      check("rst_master_readies", {ifu_arready, lsu_awready, lsu_arready, lsu_wready}, 0);
      ifu_arvalid = 1'b0; lsu_awvalid = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      // tie right after reset: IFU first, then strict alternation
      for (int i = 0; i < 4; i++) begin gq.push_back(2'd1); gq.push_back(2'd2); end
      fork
         begin for (int i = 0; i < 4; i++) ifu_read(32'h8000_1000 + 32'(i * 4)); end
         begin for (int i = 0; i < 4; i++) lsu_read(32'h8000_2000 + 32'(i * 4)); end
      join
      drain();

      // IFU alone
      check("t1_idle_before", grant, 0);
      gq.push_back(2'd1);
      ifu_read(32'h8000_0000);
      drain();
      check("t1_idle_after", grant, 0);

      // LSU write, W a cycle ahead of AW
      aw0 = aw_hs; w0 = w_hs;
      gq.push_back(2'd3);
      lsu_write(32'h8000_0100, 32'hDEAD_BEEF, 4'hF, 1'b1);
      drain();
      check("t3_aw_count", aw_hs - aw0, 1);
      check("t3_w_count", w_hs - w0, 1);
      check("t3_mem_awaddr", wr_addr, 32'h8000_0100);
      check("t3_mem_wdata", wr_data, 32'hDEAD_BEEF);
      check("t3_mem_wstrb", wr_strb, 4'hF);

      // LSU AW and AR together: write wins
      gq.push_back(2'd3); gq.push_back(2'd2);
      fork
         lsu_write(32'h8000_0180, 32'h0BAD_F00D, 4'h3, 1'b0);
         lsu_read(32'h8000_0300);
      join
      drain();
      check("t4_mem_wdata", wr_data, 32'h0BAD_F00D);
      check("t4_mem_wstrb", wr_strb, 4'h3);

      // SLVERR passes through on an IFU read
      err_resp = 2'b10;
      gq.push_back(2'd1);
      ifu_read(32'h8000_0040);
      drain();
      check("t5_idle_after_err", grant, 0);
      err_resp = 2'b00;
      check("ar_count_pre_rst", ar_hs, 11);

      // reset while LSU_RD waits on R; last served was IFU, so reset must flip the tie back to IFU
      gq.push_back(2'd2);
      lsu_araddr = 32'h8000_0200; lsu_arvalid = 1'b1;
      @(negedge clk);
      @(negedge clk); lsu_arvalid = 1'b0;
      @(negedge clk);
      check("t6_in_lsu_rd", grant, 2);
      rst = 1'b1;
      #1;
      check("t6_rst_grant", grant, 0);
      check("t6_rst_mem_valids", {mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready}, 0);
      check("t6_rst_lsu_rvalid", lsu_rvalid, 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      gq.push_back(2'd1); gq.push_back(2'd2);
      fork
         ifu_read(32'h8000_0400);
         lsu_read(32'h8000_0500);
      join
      drain();
      check("ar_count_total", ar_hs, 14);
      check("aw_count_total", aw_hs, 2);
      check("w_count_total", w_hs, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
